// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: direct-mapped BTB plus a gshare direction predictor.
// The PHT holds 2-bit saturating counters indexed by pc XOR global history.
// Lookup is combinational for the IF stage. Training comes from EX resolution.
// Optional macro BP_STATS_EN adds conditional-branch and mispredict counters.
module gshare_branch_predictor #(
    parameter int PC_WIDTH    = 32,
    parameter int BTB_ENTRIES = 32,
    parameter int GHR_BITS    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] current_pc,
    output logic [PC_WIDTH-1:0] pc_predict,
    output logic                predict_taken,
    input  logic                update_valid,
    input  logic [PC_WIDTH-1:0] update_pc,
    input  logic                update_is_cond,
    input  logic                update_taken,
    input  logic [PC_WIDTH-1:0] update_target,
    input  logic                update_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]         stat_cond_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int IDX         = $clog2(BTB_ENTRIES);
    localparam int TAG_W       = PC_WIDTH - IDX - 2;
    localparam int PHT_ENTRIES = 1 << GHR_BITS;

    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [BTB_ENTRIES-1:0] uncond_q, uncond_d;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_d    [BTB_ENTRIES];
    logic [PC_WIDTH-1:0]    target_q [BTB_ENTRIES];
    logic [PC_WIDTH-1:0]    target_d [BTB_ENTRIES];
    logic [1:0]             pht_q    [PHT_ENTRIES];
    logic [1:0]             pht_d    [PHT_ENTRIES];
    logic [GHR_BITS-1:0]    ghr_q, ghr_d;

    logic [IDX-1:0]      look_bidx;
    logic [GHR_BITS-1:0] look_pidx;
    logic [TAG_W-1:0]    look_tag;
    logic                look_hit;
    logic                taken_pred;

    logic [IDX-1:0]      upd_bidx;
    logic [GHR_BITS-1:0] upd_pidx;
    logic [TAG_W-1:0]    upd_tag;

    // Low pc bits are always zero for aligned instructions; update_mispredict
    // only feeds the optional statistics counters.
    logic [2:0] unused_bits;
    assign unused_bits = {update_pc[1:0], update_mispredict};

    assign look_bidx = current_pc[IDX+1:2];
    assign look_pidx = current_pc[GHR_BITS+1:2] ^ ghr_q;
    assign look_tag  = current_pc[PC_WIDTH-1:IDX+2];
    assign upd_bidx  = update_pc[IDX+1:2];
    assign upd_pidx  = update_pc[GHR_BITS+1:2] ^ ghr_q;
    assign upd_tag   = update_pc[PC_WIDTH-1:IDX+2];

    // Zero-latency prediction from the pre-update state.
    always_comb begin
        look_hit      = valid_q[look_bidx] && (tag_q[look_bidx] == look_tag);
        taken_pred    = look_hit && (uncond_q[look_bidx] || pht_q[look_pidx][1]);
        predict_taken = taken_pred;
        pc_predict    = taken_pred ? target_q[look_bidx] : current_pc + PC_WIDTH'(4);
    end

    // Next-state for BTB, PHT and history from a resolved EX update.
    always_comb begin
        valid_d  = valid_q;
        uncond_d = uncond_q;
        tag_d    = tag_q;
        target_d = target_q;
        pht_d    = pht_q;
        ghr_d    = ghr_q;
        if (update_valid) begin
            if (!update_is_cond) begin
                valid_d[upd_bidx]  = 1'b1;
                uncond_d[upd_bidx] = 1'b1;
                tag_d[upd_bidx]    = upd_tag;
                target_d[upd_bidx] = update_target;
            end else begin
                if (update_taken) begin
                    if (pht_q[upd_pidx] != 2'b11) begin
                        pht_d[upd_pidx] = pht_q[upd_pidx] + 2'd1;
                    end
                    valid_d[upd_bidx]  = 1'b1;
                    uncond_d[upd_bidx] = 1'b0;
                    tag_d[upd_bidx]    = upd_tag;
                    target_d[upd_bidx] = update_target;
                end else if (pht_q[upd_pidx] != 2'b00) begin
                    pht_d[upd_pidx] = pht_q[upd_pidx] - 2'd1;
                end
                ghr_d = {ghr_q[GHR_BITS-2:0], update_taken};
            end
        end
    end

    // Predictor state registers; counters come out of reset weakly not-taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            uncond_q <= '0;
            ghr_q    <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else begin
            valid_q  <= valid_d;
            uncond_q <= uncond_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            pht_q    <= pht_d;
            ghr_q    <= ghr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] cond_cnt_q, cond_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    // Free-running event counters, wrapping naturally at 2**32.
    always_comb begin
        cond_cnt_d = cond_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        if (update_valid && update_is_cond) begin
            cond_cnt_d = cond_cnt_q + 32'd1;
        end
        if (update_valid && update_mispredict) begin
            mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cond_cnt_q <= '0;
            mis_cnt_q  <= '0;
        end else begin
            cond_cnt_q <= cond_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    assign stat_cond_branches = cond_cnt_q;
    assign stat_mispredicts   = mis_cnt_q;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: directed vectors with hand-computed expectations.
// Stimulus pushes expected lookups into a queue; a negedge monitor pops and checks.
module tb_gshare_branch_predictor;

    localparam int PC_W = 32;

    logic            clk;
    logic            reset;
    logic [PC_W-1:0] current_pc;
    logic [PC_W-1:0] pc_predict;
    logic            predict_taken;
    logic            update_valid;
    logic [PC_W-1:0] update_pc;
    logic            update_is_cond;
    logic            update_taken;
    logic [PC_W-1:0] update_target;
    logic            update_mispredict;
`ifdef BP_STATS_EN
    logic [31:0]     stat_cond_branches;
    logic [31:0]     stat_mispredicts;
`endif

    typedef struct {
        int              id;
        logic [PC_W-1:0] pc;
        logic            taken;
        logic            chk_stats;
        logic [31:0]     cond_cnt;
        logic [31:0]     mis_cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks;
    int          errors;
    int          vec_id;
    logic        check_pending;
    logic        stats_pending;
    logic [31:0] stats_cond;
    logic [31:0] stats_mis;

    gshare_branch_predictor #(
        .PC_WIDTH(PC_W),
        .BTB_ENTRIES(32),
        .GHR_BITS(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .current_pc(current_pc),
        .pc_predict(pc_predict),
        .predict_taken(predict_taken),
        .update_valid(update_valid),
        .update_pc(update_pc),
        .update_is_cond(update_is_cond),
        .update_taken(update_taken),
        .update_target(update_target),
        .update_mispredict(update_mispredict)
`ifdef BP_STATS_EN
        ,
        .stat_cond_branches(stat_cond_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive inputs after the edge, queue the expected lookup result.
    task automatic applyStimulus(input logic rst_val, input logic [PC_W-1:0] pc,
                                 input logic uv, input logic [PC_W-1:0] upc,
                                 input logic cond, input logic tkn,
                                 input logic [PC_W-1:0] tgt, input logic mis,
                                 input logic [PC_W-1:0] exp_pc, input logic exp_tkn);
        exp_t e;
        @(posedge clk);
        #1;
        reset             = rst_val;
        current_pc        = pc;
        update_valid      = uv;
        update_pc         = upc;
        update_is_cond    = cond;
        update_taken      = tkn;
        update_target     = tgt;
        update_mispredict = mis;
        e.id        = vec_id;
        e.pc        = exp_pc;
        e.taken     = exp_tkn;
        e.chk_stats = stats_pending;
        e.cond_cnt  = stats_cond;
        e.mis_cnt   = stats_mis;
        vec_id        = vec_id + 1;
        stats_pending = 1'b0;
        exp_q.push_back(e);
        check_pending = 1'b1;
        @(negedge clk);
        #1;
        check_pending = 1'b0;
    endtask

    task automatic lookup(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] exp_pc,
                          input logic exp_tkn);
        applyStimulus(1'b1, pc, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, exp_pc, exp_tkn);
    endtask

    task automatic updJal(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] upc,
                          input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] exp_pc,
                          input logic exp_tkn);
        applyStimulus(1'b1, pc, 1'b1, upc, 1'b0, 1'b1, tgt, 1'b0, exp_pc, exp_tkn);
    endtask

    task automatic updCond(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] upc,
                           input logic tkn, input logic [PC_W-1:0] tgt, input logic mis,
                           input logic [PC_W-1:0] exp_pc, input logic exp_tkn);
        applyStimulus(1'b1, pc, 1'b1, upc, 1'b1, tkn, tgt, mis, exp_pc, exp_tkn);
    endtask

    task automatic doReset(input logic [PC_W-1:0] pc);
        applyStimulus(1'b0, pc, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, pc + 32'd4, 1'b0);
        applyStimulus(1'b0, pc, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, pc + 32'd4, 1'b0);
    endtask

    // Compare one scoreboard entry against what the DUT presents now.
    task automatic checkOutput(input exp_t e);
        checks = checks + 1;
        if (pc_predict !== e.pc) begin
            errors = errors + 1;
            $display("[TB] FAIL pc_predict vec%0d: got %h expected %h", e.id, pc_predict, e.pc);
        end
        checks = checks + 1;
        if (predict_taken !== e.taken) begin
            errors = errors + 1;
            $display("[TB] FAIL predict_taken vec%0d: got %b expected %b", e.id, predict_taken, e.taken);
        end
`ifdef BP_STATS_EN
        if (e.chk_stats) begin
            checks = checks + 1;
            if (stat_cond_branches !== e.cond_cnt) begin
                errors = errors + 1;
                $display("[TB] FAIL stat_cond_branches vec%0d: got %0d expected %0d",
                         e.id, stat_cond_branches, e.cond_cnt);
            end
            checks = checks + 1;
            if (stat_mispredicts !== e.mis_cnt) begin
                errors = errors + 1;
                $display("[TB] FAIL stat_mispredicts vec%0d: got %0d expected %0d",
                         e.id, stat_mispredicts, e.mis_cnt);
            end
        end
`endif
    endtask

    // Monitor: pops one expectation whenever stimulus has presented a vector.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (check_pending) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("[TB] FAIL scoreboard: got empty queue expected an entry");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput(e);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks            = 0;
        errors            = 0;
        vec_id            = 0;
        check_pending     = 1'b0;
        stats_pending     = 1'b0;
        stats_cond        = '0;
        stats_mis         = '0;
        reset             = 1'b0;
        current_pc        = 32'h40;
        update_valid      = 1'b0;
        update_pc         = '0;
        update_is_cond    = 1'b0;
        update_taken      = 1'b0;
        update_target     = '0;
        update_mispredict = 1'b0;

        // Cold lookups, unconditional install, tag mismatch, same-cycle collision.
        doReset(32'h40);
        lookup(32'h40, 32'h44, 1'b0);
        updJal(32'h10, 32'h10, 32'h80, 32'h14, 1'b0);
        lookup(32'h10, 32'h80, 1'b1);
        lookup(32'h90, 32'h94, 1'b0);
        updJal(32'h10, 32'h10, 32'h100, 32'h80, 1'b1);
        lookup(32'h10, 32'h100, 1'b1);
        // Reset mid-run with an update in flight: immediate cold response, update discarded.
        applyStimulus(1'b0, 32'h10, 1'b1, 32'h20, 1'b0, 1'b1, 32'h300, 1'b0, 32'h14, 1'b0);
        lookup(32'h20, 32'h24, 1'b0);
        lookup(32'h10, 32'h14, 1'b0);
        lookup(32'hFFFF_FFFC, 32'h0, 1'b0);

        // Gshare hashing: taken at 0x20 trains pht[8], lookup then uses pidx 9.
        doReset(32'h20);
        updCond(32'h20, 32'h20, 1'b1, 32'h08, 1'b0, 32'h24, 1'b0);
        lookup(32'h20, 32'h24, 1'b0);
        for (int i = 0; i < 5; i++) begin
            updCond(32'h20, 32'h3C, 1'b0, '0, 1'b0, 32'h24, 1'b0);
        end
        lookup(32'h20, 32'h08, 1'b1);
        lookup(32'h3C, 32'h40, 1'b0);

        // Underflow: four not-taken keep pht[15] at 00 so one taken gives 01.
        doReset(32'h3C);
        for (int i = 0; i < 4; i++) begin
            updCond(32'h3C, 32'h3C, 1'b0, '0, 1'b0, 32'h40, 1'b0);
        end
        updCond(32'h3C, 32'h3C, 1'b1, 32'h500, 1'b0, 32'h40, 1'b0);
        lookup(32'h3C, 32'h40, 1'b0);
        for (int i = 0; i < 5; i++) begin
            updCond(32'h3C, 32'h00, 1'b0, '0, 1'b0, 32'h40, 1'b0);
        end
        lookup(32'h3C, 32'h40, 1'b0);
        updCond(32'h3C, 32'h3C, 1'b1, 32'h500, 1'b0, 32'h40, 1'b0);
        for (int i = 0; i < 5; i++) begin
            updCond(32'h3C, 32'h00, 1'b0, '0, 1'b0, 32'h40, 1'b0);
        end
        lookup(32'h3C, 32'h500, 1'b1);

        // Overflow: prime ghr to all ones, then pht[31] must saturate at 11.
        doReset(32'h0);
        for (int i = 0; i < 5; i++) begin
            updCond(32'h0, 32'h80, 1'b1, 32'h600, 1'b0, 32'h04, 1'b0);
        end
        updCond(32'h0, 32'h0, 1'b1, 32'h700, 1'b0, 32'h04, 1'b0);
        for (int i = 0; i < 6; i++) begin
            updCond(32'h0, 32'h0, 1'b1, 32'h700, 1'b0, 32'h700, 1'b1);
        end
        lookup(32'h0, 32'h700, 1'b1);

`ifdef BP_STATS_EN
        // Statistics: three conditional updates and two mispredicts in total.
        doReset(32'h40);
        stats_pending = 1'b1;
        stats_cond    = 32'd0;
        stats_mis     = 32'd0;
        lookup(32'h40, 32'h44, 1'b0);
        updCond(32'h40, 32'h20, 1'b1, 32'h08, 1'b0, 32'h44, 1'b0);
        updCond(32'h40, 32'h24, 1'b0, '0, 1'b1, 32'h44, 1'b0);
        updCond(32'h40, 32'h28, 1'b1, 32'h08, 1'b0, 32'h44, 1'b0);
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h30, 1'b0, 1'b1, 32'h900, 1'b1, 32'h44, 1'b0);
        stats_pending = 1'b1;
        stats_cond    = 32'd3;
        stats_mis     = 32'd2;
        lookup(32'h40, 32'h44, 1'b0);
`endif

        // Drain: the scoreboard must be empty within a few cycles.
        update_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() != 0) begin
                @(negedge clk);
            end
        end
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
- Parametrised successor to the current BTB-only next-PC predictor.
- Direct-mapped BTB plus a gshare direction predictor: PHT of 2-bit saturating counters indexed by PC XOR global history register (GHR).
- IF stage queries it combinationally with current_pc.
- EX stage trains it with the resolved outcome of jal/jalr/branch instructions.
- Feeds the next-PC mux in IF.

Parameters:
- PC_WIDTH, 32, PC and target width.
- BTB_ENTRIES, 32, BTB depth; power of two, at least 2. IDX = log2(BTB_ENTRIES).
- GHR_BITS, 5, history length. PHT has 2**GHR_BITS entries.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- current_pc  in  PC_WIDTH  IF-stage PC to predict.
- pc_predict  out  PC_WIDTH  predicted next PC.
- predict_taken  out  1  prediction is a redirect, not pc+4.
- update_valid  in  1  EX resolved a control-flow instruction this cycle.
- update_pc  in  PC_WIDTH  PC of the resolved instruction.
- update_is_cond  in  1  1 = conditional branch, 0 = jal/jalr.
- update_taken  in  1  resolved direction; ignored when update_is_cond=0 (treated as taken).
- update_target  in  PC_WIDTH  resolved taken target.
- update_mispredict  in  1  EX detected a wrong prediction; used only by the optional feature.

Behaviour:
- Storage per BTB entry: valid, tag = pc[PC_WIDTH-1:IDX+2], target, uncond flag.
- BTB index = pc[IDX+1:2]. PHT index = pc[GHR_BITS+1:2] XOR ghr.
- Lookup is purely combinational, with zero latency:
  - hit = valid[bidx] && tag match.
  - taken_pred = hit && (uncond[bidx] || pht[pidx][1]).
  - pc_predict = taken_pred ? target[bidx] : current_pc+4, with pc+4 wrapping modulo 2**PC_WIDTH.
  - predict_taken = taken_pred.
- Training happens on a rising edge with update_valid=1:
  - Unconditional update: write the BTB entry (valid=1, tag, target, uncond=1). PHT and GHR are unchanged.
  - Conditional update: the PHT counter at index update_pc-derived XOR current ghr increments on taken (saturates at 2'b11) and decrements on not-taken (saturates at 2'b00).
  - Conditional update: ghr <= {ghr[GHR_BITS-2:0], update_taken}.
  - Conditional update, taken: write the BTB entry with uncond=0.
  - Conditional update, not taken: the BTB is untouched.
- History is non-speculative: the GHR changes only on resolved conditional updates.
- A BTB write to an occupied index overwrites it; there is no replacement policy.
- Read-before-write: a lookup in the same cycle as an update sees pre-update state. The new state is visible the following cycle.
- update_valid=0: no state changes.
- Reset (async assert, sync-safe release) sets:
  - all BTB valid=0, targets=0, uncond=0;
  - all PHT counters=2'b01 (weakly not-taken);
  - ghr=0.
  - Outputs immediately become pc_predict=current_pc+4 and predict_taken=0.
  - Reset mid-training discards any in-flight update.
- Prediction correctness is not checked internally; the CPU compares pc_predict against the resolved PC and flushes.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs stat_cond_branches (32) and stat_mispredicts (32).
  - stat_cond_branches increments on each update with update_valid && update_is_cond.
  - stat_mispredicts increments on each update with update_valid && update_mispredict.
  - Both wrap at 2**32 and reset to 0.
- Undefined: these ports and counters do not exist; update_mispredict is unused.

Test Plan:
- Cold lookup: release reset, current_pc=0x40 -> pc_predict=0x44, predict_taken=0. Assert reset mid-run after training -> same response immediately.
- Unconditional install: update jal pc=0x10 target=0x80 -> next cycle current_pc=0x10 gives pc_predict=0x80, predict_taken=1. current_pc=0x90 (same BTB index 4, different tag) -> 0x94, predict_taken=0.
- Gshare hashing: after reset, update cond pc=0x20 taken target=0x08 -> pht[8]=2'b10, ghr=5'b00001, BTB[8] valid. Lookup 0x20 now uses pidx 9 (counter 01) -> pc_predict=0x24, predict_taken=0.
- Saturation: after reset, four not-taken cond updates pc=0x3C -> pht[15]=2'b00 (no underflow), ghr=0, BTB[15] still invalid. Five taken cond updates at pc 0x0 with ghr forced via prior history -> counter stops at 2'b11.
- Same-cycle collision: update jal pc=0x10 target=0x100 while current_pc=0x10 -> that cycle pc_predict=0x14, next cycle 0x100.
- BP_STATS_EN: three cond updates (one with update_mispredict=1) plus one jal update with update_mispredict=1 -> stat_cond_branches=3, stat_mispredicts=2.
